// File: rtl/goertzel_tone_gen.sv
// Tone-burst synthesiser: zero-input resonator y(n) = y(n-1) - y(n-2) emitting
// N samples of A*sin(pi*n/3) over a valid/ready stream, one per i_clken slot.
module goertzel_tone_gen #(
  parameter int IW = 12,
  parameter int OW = 16,
  parameter int N  = 126
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clken,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic signed [IW-1:0] i_amplitude,
  input  logic                 i_ready,
  output logic signed [OW-1:0] o_sample,
  output logic                 o_valid,
  output logic                 o_last,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam logic [NW-1:0] LAST_IDX = NW'(N - 1);
  localparam logic [NW-1:0] ONE_IDX = NW'(1'b1);
  // 111/128 approximates sin(pi/3); product kept at IW+8 bits so it cannot overflow
  localparam logic signed [IW+7:0] SIN_COEF = (IW+8)'(8'd111);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Seed B = floor(A*111/128), sign-extended to the output width.
  function automatic logic signed [OW-1:0] seed_of(input logic signed [IW-1:0] amp);
    logic signed [IW+7:0] prod;
    prod = (IW+8)'(amp) * SIN_COEF;
    return OW'(prod >>> 3'd7);
  endfunction

  state_t               state_r, state_s;
  logic signed [OW-1:0] s0_r, s0_s;
  logic signed [OW-1:0] s1_r, s1_s;
  logic [NW-1:0]        n_r, n_s;
  logic                 valid_r, valid_s;
  logic                 done_r, done_s;
  logic                 busy_r, busy_s;
  logic                 last_r, last_s;

  // Next-state, resonator advance and registered-output precomputation.
  always_comb begin
    state_s = state_r;
    s0_s    = s0_r;
    s1_s    = s1_r;
    n_s     = n_r;
    valid_s = valid_r;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_start && !i_stop) begin
          s0_s    = {OW{1'b0}};
          s1_s    = seed_of(i_amplitude);
          n_s     = {NW{1'b0}};
          state_s = ST_WAIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (i_stop) begin
          valid_s = 1'b0;
          state_s = ST_IDLE;
        end else if (i_clken) begin
          valid_s = 1'b1;
          state_s = ST_HOLD;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (i_stop) begin
          valid_s = 1'b0;
          state_s = ST_IDLE;
        end else if (i_ready) begin
          valid_s = 1'b0;
          if (n_r == LAST_IDX) begin
            done_s  = 1'b1;
            state_s = ST_IDLE;
          end else begin
            n_s     = n_r + ONE_IDX;
            s0_s    = s1_r;
            s1_s    = s1_r - s0_r;
            state_s = ST_WAIT;
          end
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: begin
        valid_s = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
    last_s = valid_s && (n_s == LAST_IDX);
  end

  // State, datapath and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
      s0_r    <= {OW{1'b0}};
      s1_r    <= {OW{1'b0}};
      n_r     <= {NW{1'b0}};
      valid_r <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
      last_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      s0_r    <= s0_s;
      s1_r    <= s1_s;
      n_r     <= n_s;
      valid_r <= valid_s;
      done_r  <= done_s;
      busy_r  <= busy_s;
      last_r  <= last_s;
    end
  end

  assign o_sample = s0_r;
  assign o_valid  = valid_r;
  assign o_last   = last_r;
  assign o_busy   = busy_r;
  assign o_done   = done_r;

endmodule

// File: tb/tb_goertzel_tone_gen.sv
// Self-checking bench for goertzel_tone_gen (N=12): table of amplitude/seed
// vectors plus hand sequences, with a scoreboard queue of expected transfers.
module tb_goertzel_tone_gen;

  localparam int IW = 12;
  localparam int OW = 16;
  localparam int NB = 12;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 clken = 1'b0;
  logic                 start = 1'b0;
  logic                 stop = 1'b0;
  logic signed [IW-1:0] amp = '0;
  logic                 ready = 1'b0;
  logic signed [OW-1:0] out_sample;
  logic                 out_valid, out_last, out_busy, out_done;

  goertzel_tone_gen #(.IW(IW), .OW(OW), .N(NB)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clken(clken), .i_start(start), .i_stop(stop),
    .i_amplitude(amp), .i_ready(ready), .o_sample(out_sample), .o_valid(out_valid),
    .o_last(out_last), .o_busy(out_busy), .o_done(out_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic signed [OW-1:0] sample;
    logic                 last;
  } exp_t;

  typedef struct {
    logic signed [IW-1:0] amp;
    logic signed [OW-1:0] b;
    int                   period;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[7];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   xfer_cnt = 0;
  int   done_cnt = 0;
  int   cyc_g = 0;
  int   last_xfer_cyc = -1;
  int   exp_gap = 0;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    else pass_cnt++;
  endtask

  // Expected burst: 0, B, B, 0, -B, -B repeated, last flag on the final sample.
  task automatic push_burst(input logic signed [OW-1:0] b);
    exp_t e;
    for (int i = 0; i < NB; i++) begin
      case (i % 6)
        0, 3:    e.sample = 16'sd0;
        1, 2:    e.sample = b;
        default: e.sample = -b;
      endcase
      e.last = (i == NB - 1);
      exp_q.push_back(e);
    end
  endtask

  // Observe outputs at the negedge; a transfer happens at the next posedge.
  task automatic tick();
    exp_t e;
    if (rst_n && out_valid && ready && !stop) begin
      xfer_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_xfer", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("sample", out_sample, e.sample);
        check("last", out_last, e.last);
      end
      if (exp_gap != 0 && last_xfer_cyc >= 0) check("gap", cyc_g - last_xfer_cyc, exp_gap);
      last_xfer_cyc = cyc_g;
    end
    if (out_done) done_cnt++;
    cyc_g++;
    @(negedge clk);
  endtask

  task automatic start_burst(input logic signed [IW-1:0] a, input logic signed [OW-1:0] b, input int gap);
    amp = a;
    start = 1'b1;
    push_burst(b);
    last_xfer_cyc = -1;
    exp_gap = gap;
    tick();
    start = 1'b0;
    check("busy_after_start", out_busy, 1);
  endtask

  task automatic run_until(input int target, input int period, input int phase, input bit rdy);
    int c = 0;
    while (exp_q.size() > target && c < 200) begin
      clken = ((c + phase) % period == 0);
      ready = rdy;
      tick();
      c++;
    end
    if (exp_q.size() > target) check("run_timeout", exp_q.size(), target);
  endtask

  task automatic wait_valid();
    int c = 0;
    clken = 1'b1;
    ready = 1'b0;
    while (!out_valid && c < 50) begin
      tick();
      c++;
    end
    check("wait_valid", out_valid, 1);
  endtask

  task automatic check_end();
    check("done_pulse", out_done, 1);
    check("busy_end", out_busy, 0);
    check("valid_end", out_valid, 0);
    clken = 1'b0;
    tick();
    check("done_clear", out_done, 0);
  endtask

  initial begin
    int x0, d0, vcnt;
    vecs[0] = '{12'sd1000, 16'sd867, 1};
    vecs[1] = '{-12'sd1000, -16'sd868, 1};
    vecs[2] = '{-12'sd2048, -16'sd1776, 1};
    vecs[3] = '{12'sd0, 16'sd0, 1};
    vecs[4] = '{12'sd2047, 16'sd1775, 1};
    vecs[5] = '{-12'sd1, -16'sd1, 1};
    vecs[6] = '{12'sd1000, 16'sd867, 4};

    @(negedge clk);
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_sample", out_sample, 0);
    check("rst_busy", out_busy, 0);
    check("rst_last", out_last, 0);
    check("rst_done", out_done, 0);
    rst_n = 1'b1;
    tick();

    // Table-driven bursts; period 4 exercises i_clken decimation.
    for (int v = 0; v < 7; v++) begin
      x0 = xfer_cnt;
      start_burst(vecs[v].amp, vecs[v].b, 2 * ((vecs[v].period > 1) ? vecs[v].period / 2 : 1));
      clken = 1'b1;
      ready = 1'b1;
      tick();
      check("latency_valid", out_valid, 1);
      run_until(0, vecs[v].period, 1, 1'b1);
      check("xfer_count", xfer_cnt - x0, NB);
      check_end();
    end

    // Back-pressure: stall sample index 3 (value 0) for 7 cycles.
    start_burst(12'sd1000, 16'sd867, 0);
    run_until(9, 1, 0, 1'b1);
    wait_valid();
    for (int i = 0; i < 7; i++) begin
      tick();
      check("bp_valid", out_valid, 1);
      check("bp_sample", out_sample, 0);
    end
    run_until(0, 1, 0, 1'b1);
    check_end();

    // i_start mid-burst with a different amplitude is ignored.
    start_burst(12'sd1000, 16'sd867, 2);
    run_until(6, 1, 0, 1'b1);
    start = 1'b1;
    amp = -12'sd2048;
    tick();
    tick();
    start = 1'b0;
    run_until(0, 1, 0, 1'b1);
    check_end();

    // Start and stop together in IDLE: stop wins.
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    check("start_stop_idle", out_busy, 0);

    // Stop in HOLD coinciding with ready: abort, no done, no further valid.
    start_burst(12'sd1000, 16'sd867, 2);
    run_until(8, 1, 0, 1'b1);
    wait_valid();
    d0 = done_cnt;
    stop = 1'b1;
    ready = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_busy", out_busy, 0);
    check("stop_valid", out_valid, 0);
    check("stop_done", out_done, 0);
    exp_q.delete();
    vcnt = 0;
    clken = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) vcnt++;
      tick();
    end
    check("stop_no_valid", vcnt, 0);
    check("stop_no_done", done_cnt - d0, 0);

    // Back-to-back: new start on the o_done cycle.
    start_burst(12'sd500, 16'sd433, 2);
    run_until(0, 1, 0, 1'b1);
    check("b2b_done", out_done, 1);
    start_burst(-12'sd1000, -16'sd868, 2);
    run_until(0, 1, 0, 1'b1);
    check_end();

    // Asynchronous reset between edges while in HOLD.
    start_burst(12'sd1000, 16'sd867, 2);
    run_until(10, 1, 0, 1'b1);
    wait_valid();
    check("pre_rst_sample", out_sample, 867);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_sample", out_sample, 0);
    check("arst_busy", out_busy, 0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("arst_no_done", out_done, 0);
    ready = 1'b1;
    start_burst(12'sd1000, 16'sd867, 2);
    run_until(0, 1, 0, 1'b1);
    check_end();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/goertzel_tone_gen.md
Name: goertzel_tone_gen

Overview:
Fixed-frequency tone-burst synthesiser. It is the transmit-side counterpart of the k/N = 1/6 Goertzel detector. It runs the same second-order recursion as a zero-input resonator, y(n) = y(n-1) - y(n-2) (2cos(PI/3) = 1), and emits N samples of A·sin(PI·n/3), one sample per i_clken slot, over a valid/ready stream. It generates known-frequency stimulus for the Goertzel receive chain and drives the DAC path.

Parameters:
- IW, 12: amplitude input width, signed, A(1,10) format.
- OW, 16: output sample width, signed, same binary point as the input. OW >= IW.
- N, 126: samples per burst. N >= 2. Counter width is NW = $clog2(N).

Ports:
- i_clk, input, 1: clock.
- i_rst_n, input, 1: reset, asynchronous, active-low.
- i_clken, input, 1: sample-rate enable. One new sample may be presented per asserted cycle.
- i_start, input, 1: begin a burst. Sampled in IDLE only.
- i_stop, input, 1: abort the current burst.
- i_amplitude, input, IW: signed peak amplitude A. Latched at start.
- i_ready, input, 1: downstream accepts o_sample.
- o_sample, output, OW: current sample, signed.
- o_valid, output, 1: o_sample is valid.
- o_last, output, 1: o_valid && n == N-1.
- o_busy, output, 1: state != IDLE.
- o_done, output, 1: one-cycle pulse after the final transfer.

Behaviour:
- Reset (i_rst_n low, asynchronous): state IDLE; s0, s1, n all zero; o_valid=0, o_done=0, o_sample=0, o_busy=0, o_last=0.
- Registers: s0 holds the current sample and drives o_sample. s1 holds the next sample. n is the burst index.
- Seeds: B = (A * 8'sd111) >>> 7. This is an arithmetic (floor) shift: 111/128 ≈ sin(PI/3). Compute at IW+8 bits, then sign-extend to OW.
- Advance step: s0 <= s1; s1 <= s1 - s0, in OW-bit arithmetic. The sequence is exactly 0, B, B, 0, -B, -B with period 6 and no drift.
- FSM states: IDLE, WAIT, HOLD.
- IDLE:
  - On i_start: latch seeds (s0 <= 0, s1 <= B), n <= 0, go to WAIT.
  - Otherwise stay in IDLE.
- WAIT (o_valid=0): on i_clken, set o_valid <= 1 and go to HOLD. s0 is not modified.
- HOLD (o_valid=1): o_sample is stable while i_ready=0, with no cycle limit. A transfer is o_valid && i_ready.
  - Transfer with n == N-1: o_valid <= 0, o_done <= 1 for one cycle, go to IDLE.
  - Other transfer: n <= n+1, advance step, o_valid <= 0, go to WAIT.
- Spacing: minimum spacing between consecutive samples is 2 cycles, even with i_clken=1 and i_ready=1. i_clken asserted while in HOLD is ignored; it is not queued.
- Latency: with i_start at edge k and i_clken held high, o_valid rises after edge k+1.
- i_stop: in WAIT or HOLD, the next edge goes to IDLE with o_valid <= 0 and no o_done. i_stop has priority over a simultaneous transfer. In IDLE it is ignored.
- i_start in WAIT or HOLD is ignored. i_start and i_stop together in IDLE: i_stop wins and the block stays in IDLE.
- o_done and a new i_start: a new i_start is accepted on the cycle o_done is high, because the state is IDLE by then.
- Reset mid-burst: immediate return to the reset values above, with no o_done.
- Amplitude range:
  - A = -2^(IW-1) is legal: B = -1776 for IW = 12, and -B fits.
  - A = 0 gives an all-zero burst that still has N transfers.

Test Plan:
- Basic burst:
  - Stimulus: A=1000, N=12, i_clken=1, i_ready=1, i_start pulse.
  - Required: 12 transfers, one every 2 cycles, values 0,867,867,0,-867,-867 repeated twice.
  - Required: o_last on transfer 12; o_done one cycle later; o_busy falls with o_done.
- Negative and extreme amplitude:
  - A=-1000 → sequence 0,-868,-868,0,868,868.
  - A=-2048 → ±1776 with no wrap.
  - A=0 → 12 zero samples.
- Back-pressure:
  - Stimulus: hold i_ready=0 for 7 cycles during sample 3 (value 0), with A=1000.
  - Required: o_sample and o_valid stay stable; the rest of the sequence is unchanged after release.
- Decimation:
  - Stimulus: i_clken high 1 cycle in 4, i_ready=1.
  - Required: exactly one transfer per i_clken pulse; samples are spaced 4 cycles apart.
- Control corner cases:
  - i_start mid-burst with a different A is ignored; the amplitude is unchanged.
  - i_stop during HOLD coinciding with i_ready → IDLE, no o_done, no further valid.
  - Back-to-back bursts: i_start on the o_done cycle starts a new burst correctly.
- Asynchronous reset:
  - Stimulus: assert i_rst_n low between clock edges while in HOLD.
  - Required: o_valid, o_sample and o_busy go to 0 immediately.
  - Required: after release, a fresh i_start produces a sequence starting at 0.
